// File: rtl/nes_controller_emulator.sv
// Console-facing emulation of one or more 4021-based NES pads.
//
// The console's latch and shift clock arrive asynchronously and are resynchronized here.
// While the synchronized latch is high every pad's shift register parallel-loads its
// button byte. After the latch falls, each rising console clock shifts one bit out, MSB
// first and active-low.
//
// Ports:
//   clk                        system clock; must run at least 2*(SYNC_STAGES+2) times the
//                              console clock frequency
//   rst                        synchronous, active-high reset
//   controller_latch_i         console latch (async, active-high)
//   controller_clk_i           console shift clock (async, shifts on its rising edge)
//   buttons_LIST_i             pressed=1; pad n uses [8n+7:8n]; bit7=A ... bit0=Right
//   controller_serial_LIST_no  per-pad serial data, active-low
//   latched_o                  one-cycle pulse when the latch has fallen
//   done_o                     one-cycle pulse on the 8th accepted shift
//   bits_sent_o                shifts since the last latch, saturating at 8
module nes_controller_emulator #(
  parameter int unsigned NUM_CONTROLLERS = 4,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         controller_latch_i,
  input  logic                         controller_clk_i,
  input  logic [8*NUM_CONTROLLERS-1:0] buttons_LIST_i,
  output logic [NUM_CONTROLLERS-1:0]   controller_serial_LIST_no,
  output logic                         latched_o,
  output logic                         done_o,
  output logic [3:0]                   bits_sent_o
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] latch_sync_q, clk_sync_q;
  logic                   latch_hist_q, clk_hist_q;
  logic                   clk_rise_q;
  logic                   latch_s, clk_s;

  logic [NUM_CONTROLLERS-1:0][7:0] sr_q, sr_d;
  logic [3:0]                      cnt_q, cnt_d;
  logic                            latched_q, latched_d;
  logic                            done_q, done_d;

  assign latch_s = latch_sync_q[SYNC_STAGES-1];
  assign clk_s   = clk_sync_q[SYNC_STAGES-1];

  // Synchronizers, history flops and a registered clock-rise pulse. The latch is acted on
  // through its history flop so that latch and clock events see the same total latency
  // from the pins: SYNC_STAGES+1 clk edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      latch_sync_q <= '0;
      clk_sync_q   <= '0;
      latch_hist_q <= 1'b0;
      clk_hist_q   <= 1'b0;
      clk_rise_q   <= 1'b0;
    end else begin
      latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], controller_latch_i};
      clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], controller_clk_i};
      latch_hist_q <= latch_s;
      clk_hist_q   <= clk_s;
      clk_rise_q   <= clk_s & ~clk_hist_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      sr_q      <= '0;
      cnt_q     <= 4'd0;
      latched_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      latched_q <= latched_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    latched_d = 1'b0;
    done_d    = 1'b0;
    if (latch_hist_q) begin
      // Latch high in any state: parallel load, abandoning any partial transfer.
      sr_d    = buttons_LIST_i;
      cnt_d   = 4'd0;
      state_d = StLoad;
    end else begin
      unique case (state_q)
        StIdle: ;
        StLoad: begin
          state_d   = StShift;
          latched_d = 1'b1;
        end
        StShift: begin
          if (clk_rise_q) begin
            for (int n = 0; n < NUM_CONTROLLERS; n++) begin
              sr_d[n] = {sr_q[n][6:0], 1'b1};
            end
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              state_d = StDone;
              done_d  = 1'b1;
            end
          end
        end
        StDone: begin
          // Mimics the real pad's grounded serial input: extra clocks shift in 1s.
          if (clk_rise_q) begin
            for (int n = 0; n < NUM_CONTROLLERS; n++) begin
              sr_d[n] = {sr_q[n][6:0], 1'b1};
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    for (int n = 0; n < NUM_CONTROLLERS; n++) begin
      controller_serial_LIST_no[n] = ~sr_q[n][7];
    end
  end

  assign latched_o   = latched_q;
  assign done_o      = done_q;
  assign bits_sent_o = cnt_q;

endmodule

// File: doc/nes_controller_emulator.md
Name: nes_controller_emulator

Overview:
- Device-side (console-facing) end of the NES controller serial protocol; emulates one or more 4021-based pads so the FPGA can feed button states to a real console or to a host-side poller.
- Samples the console's asynchronous latch and clock lines, parallel-loads button bytes while latch is high, and shifts one active-low bit per controller-clock rising edge.
- Sits between the button-source logic (USB/UART bridge, test sequencer) and the controller connector pins.

Parameters:
- NUM_CONTROLLERS, 4, number of emulated pads; sets the widths of buttons_LIST_i and controller_serial_LIST_no.
- SYNC_STAGES, 2, flop depth of the synchronizer on controller_clk_i and on controller_latch_i; legal values are 2 or more.

Ports:
- clk  input  1  system clock; must be at least 2*(SYNC_STAGES+2) times the controller clock frequency.
- rst  input  1  synchronous, active-high reset.
- controller_latch_i  input  1  console latch, asynchronous to clk, active-high.
- controller_clk_i  input  1  console shift clock, asynchronous to clk; shifts on its rising edge.
- buttons_LIST_i  input  8*NUM_CONTROLLERS  pressed=1; pad n uses bits [8n+7:8n]; bit 7=A, 6=B, 5=Select, 4=Start, 3=Up, 2=Down, 1=Left, 0=Right.
- controller_serial_LIST_no  output  NUM_CONTROLLERS  serial data, active-low (0 = pressed).
- latched_o  output  1  one-cycle pulse when the synchronized latch falls.
- done_o  output  1  one-cycle pulse on the 8th accepted shift.
- bits_sent_o  output  4  count of shifts since the last latch, saturating at 8.

Behaviour:
- Sync: SYNC_STAGES flops on each of latch and clk, plus one history flop per line for edge detection. latch_s and clk_s denote the synchronized values.
- Per pad: an 8-bit shift register sr_n. controller_serial_LIST_no[n] = ~sr_n[7] combinationally from the register. No other logic sits in the path.
- FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE: entered from reset. sr is held. latch_s=1 -> LOAD.
  - LOAD: every cycle with latch_s=1, sr_n <= buttons_LIST_i[8n+:8] and bits_sent <= 0. Clock edges are ignored (4021 parallel mode). On the latch_s falling edge -> SHIFT, with latched_o=1 for 1 cycle. The final value in sr is the buttons input at the last cycle latch_s was 1.
  - SHIFT: on a clk_s rising edge, sr_n <= {sr_n[6:0],1'b1} and bits_sent++. When the 8th shift completes -> DONE, with done_o=1 in the same cycle as that sr update.
  - DONE: sr is all ones, so every serial line is 0 (console reads 1s, matching the real pad's grounded serial input). Further clk_s edges shift in more 1s; bits_sent stays at 8.
- latch_s rising in any state (including mid-SHIFT): go to LOAD immediately and reload that cycle. The partial transfer is abandoned and done_o does not pulse.
- Latency: an input edge first sampled high at clk edge k updates sr at edge k+SYNC_STAGES+1. The serial output is valid from that edge on.
- Input timing: each latch and clock phase must last at least SYNC_STAGES+2 clk cycles. Shorter pulses may be missed; the block must not misbehave other than missing them.
- rst mid-transfer: all sr=0 (serial lines=1, released), state=IDLE, bits_sent=0, latched_o=done_o=0, synchronizer and history flops=0. Reset has priority over all events.
- The NUM_CONTROLLERS pads share the latch, clock, FSM and counter; only sr is per pad.

Test Plan:
1. Reset, inputs idle -> controller_serial_LIST_no=4'hF, bits_sent_o=0, latched_o=done_o=0 for 20 cycles.
2. buttons_LIST_i=32'h81_00_FF_5A, latch high for 12 cycles then low, then 8 clock pulses of 8 high/8 low cycles:
   - latched_o pulses once.
   - Pad0 serial bits sample 1,0,1,0,0,1,0,1 (~0x5A, MSB first).
   - Pad3 serial bits sample 0,1,1,1,1,1,1,0.
   - done_o pulses on the 8th shift, and bits_sent_o=8.
3. After test 2, 3 extra clock pulses -> all serial lines 0, bits_sent_o stays 8, no further done_o.
4. buttons_LIST_i changed 0x00 -> 0xFF while latch is high, latch then falls, console clocks while latch is high -> shifted data is 0xFF, and bits_sent_o=0 until latch falls.
5. Latch re-asserted after 3 shifts with buttons=0x0F -> reload, bits_sent_o=0, no done_o; the next 8 shifts deliver 0x0F.
6. rst asserted after 4 shifts -> next cycle serial=4'hF and state IDLE; a fresh latch+8-clock sequence completes normally.
